functional_unit_buf: RTL and testbench

//  Next-generation CGRA processing-element datapath.
//  Two-operand ALU with an extended operation set, plus a reduction (feedback) mode with a programmable reduction length.

---
 rtl/functional_unit_buf.sv | 156 +++++++++++++++
 tb/tb_functional_unit_buf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/functional_unit_buf.sv
// CGRA processing-element datapath: two-operand ALU with a reduction (feedback) mode,
// feeding a small output FIFO so that din_r is driven only from registered state.
module functional_unit_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din_1,
  input  logic [DATA_WIDTH-1:0] din_2,
  input  logic                  din_v,
  output logic                  din_r,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_v,
  input  logic                  dout_r,
  input  logic                  feedback,
  input  logic [DATA_WIDTH-1:0] initial_value,
  input  logic [LEN_WIDTH-1:0]  red_len,
  input  logic [3:0]            alu_sel,
  output logic                  busy
);

  // state  | meaning
  // S_LOAD | accumulator not seeded; seeds from initial_value this cycle, din_r=0
  // S_ACC  | accumulator seeded; accepts operands until the reduction completes

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic {S_LOAD, S_ACC} state_t;

  state_t                state, state_nxt;
  logic                  started;
  logic [DATA_WIDTH-1:0] acc, acc_nxt;
  logic [LEN_WIDTH-1:0]  acc_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  full, fire, pop, push, last;
  logic [DATA_WIDTH-1:0] operand_b, alu_res;
  logic [LEN_WIDTH:0]    red_target, cnt_inc;

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [3:0] sel,
                                                input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic [SW-1:0] sh;
    logic          lt;
    sh = b[SW-1:0];
    lt = $signed(a) < $signed(b);
    case (sel)
      4'd1:    alu = a * b;
      4'd2:    alu = a - b;
      4'd3:    alu = a & b;
      4'd4:    alu = a | b;
      4'd5:    alu = a ^ b;
      4'd6:    alu = a << sh;
      4'd7:    alu = a >> sh;
      4'd8:    alu = $signed(a) >>> sh;
      4'd9:    alu = {{(DATA_WIDTH-1){1'b0}}, lt};
      4'd10:   alu = lt ? a : b;
      4'd11:   alu = lt ? b : a;
      default: alu = a + b;
    endcase
  endfunction

  assign full      = (count == (PW+1)'(DEPTH));
  assign din_r     = started && !full && (!feedback || state == S_ACC);
  assign fire      = din_v && din_r;
  assign dout_v    = (count != '0);
  assign pop       = dout_v && dout_r;
  assign dout      = mem[rd_ptr];
  assign busy      = (acc_cnt != '0);
  assign operand_b = feedback ? acc : din_2;
  assign alu_res   = alu(alu_sel, din_1, operand_b);

  // red_len==0 behaves as 1; the extra bit keeps the compare free of wrap at 2^LEN_WIDTH
  assign red_target = (red_len == '0) ? (LEN_WIDTH+1)'(1) : {1'b0, red_len};
  assign cnt_inc    = {1'b0, acc_cnt} + (LEN_WIDTH+1)'(1);
  assign last       = (cnt_inc == red_target);
  assign push       = fire && (!feedback || last);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = acc_cnt;
    if (!feedback) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          acc_nxt   = initial_value;
          state_nxt = S_ACC;
        end
        S_ACC: begin
          if (fire) begin
            if (last) begin
              cnt_nxt   = '0;
              state_nxt = S_LOAD;
            end else begin
              acc_nxt = alu_res;
              cnt_nxt = cnt_inc[LEN_WIDTH-1:0];
            end
          end
        end
        default: state_nxt = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LOAD;
      started <= 1'b0;
      acc     <= '0;
      acc_cnt <= '0;
    end else if (clr) begin
      state   <= S_LOAD;
      started <= 1'b0;
      acc     <= '0;
      acc_cnt <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      acc     <= acc_nxt;
      acc_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= alu_res;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_functional_unit_buf.sv
// Directed bench for functional_unit_buf: streaming ALU, backpressure, reductions and clr.
module tb_functional_unit_buf;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic [31:0] din_1, din_2, dout, initial_value;
  logic        din_v, din_r, dout_v, dout_r, feedback, busy;
  logic [15:0] red_len;
  logic [3:0]  alu_sel;

  int total = 0;
  int bad   = 0;

  functional_unit_buf #(.DATA_WIDTH(32), .LEN_WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .din_1(din_1), .din_2(din_2), .din_v(din_v), .din_r(din_r),
    .dout(dout), .dout_v(dout_v), .dout_r(dout_r),
    .feedback(feedback), .initial_value(initial_value), .red_len(red_len),
    .alu_sel(alu_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  op_sel [9];
  logic [31:0] op_a   [9];
  logic [31:0] op_b   [9];
  logic [31:0] op_exp [9];

  initial begin
    op_sel[0] = 4'd8;  op_a[0] = 32'h8000_0000; op_b[0] = 32'd4;        op_exp[0] = 32'hF800_0000;
    op_sel[1] = 4'd9;  op_a[1] = 32'hFFFF_FFFF; op_b[1] = 32'd1;        op_exp[1] = 32'd1;
    op_sel[2] = 4'd10; op_a[2] = 32'hFFFF_FFFB; op_b[2] = 32'd3;        op_exp[2] = 32'hFFFF_FFFB;
    op_sel[3] = 4'd11; op_a[3] = 32'hFFFF_FFFB; op_b[3] = 32'd3;        op_exp[3] = 32'd3;
    op_sel[4] = 4'd1;  op_a[4] = 32'h0001_0000; op_b[4] = 32'h0001_0000; op_exp[4] = 32'd0;
    op_sel[5] = 4'd2;  op_a[5] = 32'd3;         op_b[5] = 32'd5;        op_exp[5] = 32'hFFFF_FFFE;
    op_sel[6] = 4'd7;  op_a[6] = 32'h8000_0000; op_b[6] = 32'd4;        op_exp[6] = 32'h0800_0000;
    op_sel[7] = 4'd6;  op_a[7] = 32'd1;         op_b[7] = 32'd36;       op_exp[7] = 32'd16;
    op_sel[8] = 4'd13; op_a[8] = 32'd1;         op_b[8] = 32'd2;        op_exp[8] = 32'd3;

    rst_n = 1'b0; clr = 1'b0; din_1 = '0; din_2 = '0; din_v = 1'b0; dout_r = 1'b0;
    feedback = 1'b0; initial_value = '0; red_len = '0; alu_sel = '0;
    #12;
    chk("rst_dout", dout, 32'd0);
    chk("rst_dout_v", dout_v, 0);
    chk("rst_din_r", din_r, 0);
    chk("rst_busy", busy, 0);
    #5 rst_n = 1'b1;
    #1 chk("din_r_before_edge", din_r, 0);
    step();
    chk("din_r_after_edge", din_r, 1);

    // 1: streaming add
    dout_r = 1'b1; alu_sel = 4'd0;
    din_v = 1'b1; din_1 = 32'd3; din_2 = 32'd4;
    step();
    chk("s1_dout_v", dout_v, 1);
    chk("s1_dout_7", dout, 32'd7);
    din_1 = 32'd10; din_2 = 32'hFFFF_FFFE;
    step();
    chk("s1_dout_8", dout, 32'd8);
    din_v = 1'b0;
    step();
    chk("s1_drained", dout_v, 0);

    // 2: backpressure
    dout_r = 1'b0; din_v = 1'b1; din_1 = 32'd1; din_2 = 32'd1;
    step();
    chk("bp_din_r_1", din_r, 1);
    din_1 = 32'd2; din_2 = 32'd2;
    step();
    chk("bp_full_din_r", din_r, 0);
    chk("bp_head", dout, 32'd2);
    din_1 = 32'd3; din_2 = 32'd3;
    step();
    chk("bp_hold_dout", dout, 32'd2);
    chk("bp_hold_din_r", din_r, 0);
    dout_r = 1'b1;
    step();
    chk("bp_out_2nd", dout, 32'd4);
    chk("bp_din_r_back", din_r, 1);
    step();
    chk("bp_out_3rd", dout, 32'd6);
    din_v = 1'b0;
    step();
    chk("bp_empty", dout_v, 0);

    // 3: reduction add, seed 100, length 4
    feedback = 1'b1; initial_value = 32'd100; red_len = 16'd4; alu_sel = 4'd0;
    #1 chk("r3_load_din_r", din_r, 0);
    step();
    chk("r3_acc_din_r", din_r, 1);
    chk("r3_busy0", busy, 0);
    din_v = 1'b1; din_1 = 32'd1;
    step();
    chk("r3_busy1", busy, 1);
    din_1 = 32'd2;
    step();
    din_1 = 32'd3;
    step();
    chk("r3_busy3", busy, 1);
    chk("r3_no_early_out", dout_v, 0);
    din_1 = 32'd4;
    step();
    chk("r3_result", dout, 32'd110);
    chk("r3_result_v", dout_v, 1);
    chk("r3_busy_done", busy, 0);
    chk("r3_reload_din_r", din_r, 0);
    din_v = 1'b0;
    step();
    chk("r3_popped", dout_v, 0);
    chk("r3_acc_again", din_r, 1);

    // 4: red_len=0 acts as 1, mul seed 5
    feedback = 1'b0;
    step();
    feedback = 1'b1; red_len = 16'd0; alu_sel = 4'd1; initial_value = 32'd5;
    #1 chk("r4_load_din_r", din_r, 0);
    step();
    din_v = 1'b1; din_1 = 32'd3;
    step();
    chk("r4_first", dout, 32'd15);
    chk("r4_load_between", din_r, 0);
    step();
    chk("r4_popped", dout_v, 0);
    chk("r4_ready", din_r, 1);
    step();
    chk("r4_second", dout, 32'd15);
    chk("r4_second_v", dout_v, 1);
    din_v = 1'b0;
    step();

    // 5: ALU op table, streaming
    feedback = 1'b0; din_v = 1'b1;
    for (int i = 0; i < 9; i++) begin
      alu_sel = op_sel[i]; din_1 = op_a[i]; din_2 = op_b[i];
      step();
      chk($sformatf("alu_op%0d", op_sel[i]), dout, op_exp[i]);
    end
    din_v = 1'b0;
    step();
    chk("alu_drained", dout_v, 0);

    // 6: clr mid-reduction with one entry held
    dout_r = 1'b0; din_v = 1'b1; din_1 = 32'h55; din_2 = 32'd0; alu_sel = 4'd0;
    step();
    din_v = 1'b0; feedback = 1'b1; red_len = 16'd4; initial_value = 32'd10;
    step();
    din_v = 1'b1; din_1 = 32'd1;
    step();
    din_1 = 32'd2;
    step();
    chk("c6_busy_pre", busy, 1);
    chk("c6_held", dout, 32'h55);
    din_v = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("c6_clr_dout_v", dout_v, 0);
    chk("c6_clr_busy", busy, 0);
    chk("c6_clr_din_r", din_r, 0);
    initial_value = 32'd0; dout_r = 1'b1;
    step();
    chk("c6_ready", din_r, 1);
    din_v = 1'b1; din_1 = 32'd1;
    step();
    step();
    step();
    chk("c6_busy3", busy, 1);
    step();
    chk("c6_result", dout, 32'd4);
    chk("c6_result_v", dout_v, 1);
    din_v = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
